// File: rtl/add_accum.sv
`default_nettype none
// ============================================================================
// Module   : add_accum
// Purpose  : Accumulates batches of COUNT sums from the adder stage and
//            presents total, beat count and sticky carry-out to the sink.
// Revision : 1.0 - initial release
// ============================================================================
module add_accum #(
    parameter int WIDTH = 32,
    parameter int COUNT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;
    localparam logic [7:0] c_count = 8'(COUNT);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf;

    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] w_acc_next;
    logic [7:0]       w_cnt_next;
    logic             w_ovf_next;
    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [7:0]       w_cnt_inc;

    assign in_ready  = (r_state == S_ACCUM);
    assign out_valid = (r_state == S_HOLD);
    assign out_sum   = r_acc;
    assign out_count = r_cnt;
    assign out_ovf   = r_ovf;

    assign w_accept  = in_ready & in_valid;
    assign w_sum     = {1'b0, r_acc} + {1'b0, in_data};
    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;
        case (r_state)
            S_ACCUM: begin
                if (w_accept) begin
                    w_acc_next = w_sum[WIDTH-1:0];
                    w_ovf_next = r_ovf | w_sum[WIDTH];
                    w_cnt_next = w_cnt_inc;
                end
                // A flush with nothing accumulated (and no beat this cycle) is a no-op.
                if ((w_accept && (w_cnt_inc == c_count)) ||
                    (flush && (w_cnt_next != 8'd0))) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_acc_next   = '0;
                    w_cnt_next   = 8'd0;
                    w_ovf_next   = 1'b0;
                    w_state_next = S_ACCUM;
                end
            end
            default: begin
                w_state_next = S_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_ACCUM;
            r_acc   <= '0;
            r_cnt   <= 8'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_ovf   <= w_ovf_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_accum
// Purpose  : Directed self-checking bench for add_accum (COUNT=4 and COUNT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_accum;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_ovf;
    logic [31:0] in_data, out_sum;
    logic [7:0]  out_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ovf;
    logic [31:0] b_in_data, b_out_sum;
    logic [7:0]  b_out_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    add_accum #(.WIDTH(32), .COUNT(4)) u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    add_accum #(.WIDTH(32), .COUNT(1)) u_dut_c1 (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .flush(1'b0),
        .out_valid(b_out_valid), .out_ready(1'b1),
        .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", out_sum, 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);

        // Full batch 1..4
        for (int i = 1; i <= 4; i++) beat(32'(i));
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_sum", out_sum, 32'd10);
        check("full_count", 32'(out_count), 32'd4);
        check("full_ovf", 32'(out_ovf), 32'd0);
        tick();
        check("full_valid_drop", 32'(out_valid), 32'd0);
        check("full_in_ready_back", 32'(in_ready), 32'd1);

        // Wrap with sticky carry, then a clean batch
        beat(32'hFFFF_FFFF); beat(32'h2); beat(32'h1); beat(32'h1);
        check("wrap_sum", out_sum, 32'h3);
        check("wrap_ovf", 32'(out_ovf), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) beat(32'h1);
        check("clean_sum", out_sum, 32'h4);
        check("clean_ovf", 32'(out_ovf), 32'd0);
        tick();

        // Flush of a partial batch
        beat(32'd5); beat(32'd7);
        tick(); tick();
        check("pre_flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd1);
        check("flush_sum", out_sum, 32'd12);
        check("flush_count", 32'(out_count), 32'd2);
        tick();
        // Flush with nothing accumulated
        flush = 1'b1; tick(); flush = 1'b0;
        check("empty_flush_valid", 32'(out_valid), 32'd0);
        check("empty_flush_ready", 32'(in_ready), 32'd1);
        check("empty_flush_count", 32'(out_count), 32'd0);
        // Flush together with a beat
        flush = 1'b1; beat(32'd9); flush = 1'b0;
        check("flush_beat_valid", 32'(out_valid), 32'd1);
        check("flush_beat_sum", out_sum, 32'd9);
        check("flush_beat_count", 32'(out_count), 32'd1);
        tick();

        // Sink backpressure with pending input
        beat(32'h10); beat(32'h20); beat(32'h30);
        out_ready = 1'b0;
        beat(32'h04);
        in_valid = 1'b1; in_data = 32'h11;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", out_sum, 32'h64);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_count", 32'(out_count), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_pending_count", 32'(out_count), 32'd1);
        check("bp_pending_sum", out_sum, 32'h11);
        beat(32'h1); beat(32'h1); beat(32'h1);
        check("bp_next_sum", out_sum, 32'h14);
        check("bp_next_count", 32'(out_count), 32'd4);
        tick();

        // Reset mid-batch
        beat(32'd1); beat(32'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("midrst_count", 32'(out_count), 32'd0);
        check("midrst_sum", out_sum, 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        // Reset during HOLD
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'd2);
        check("hold_before_rst", 32'(out_valid), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("holdrst_valid", 32'(out_valid), 32'd0);
        check("holdrst_sum", out_sum, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(32'd1);
        check("after_rst_sum", out_sum, 32'd4);
        check("after_rst_count", 32'(out_count), 32'd4);
        tick();

        // COUNT=1 instance, input valid held high
        b_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_in_data = 32'(3 + k);
            tick();
            check("c1_valid", 32'(b_out_valid), 32'd1);
            check("c1_sum", b_out_sum, 32'(3 + k));
            check("c1_count", 32'(b_out_count), 32'd1);
            check("c1_in_ready", 32'(b_in_ready), 32'd0);
            tick();
            if (k == 2) b_in_valid = 1'b0;
            check("c1_gap_valid", 32'(b_out_valid), 32'd0);
        end
        tick();
        check("c1_idle_valid", 32'(b_out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
